// File: rtl/apu_dispatcher.sv
// APU request initiator: tags core FP ops with a slot ID, reorders nothing, returns results in arrival order.
// Latency: apu_req_o one cycle after accept; write-back valid one cycle after the response.
// Backpressure: core_ready_o drops on pending ungranted request or when credits reach MAX_OUTSTANDING.
module apu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign rd_vld  = (cnt != '0);
    assign rd_dat  = mem[rd_ptr];
    assign do_pop  = rd_vld & rd_rdy;
    // A pop frees the head slot in the same cycle, so a full FIFO still takes a push alongside a pop.
    assign do_push = wr_vld & ((cnt != (AW+1)'(DEPTH)) | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module apu_dispatcher #(
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 2,
    parameter int OPCODE_WIDTH    = 6,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int REGADDR_WIDTH   = 6,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          core_valid_i,
    output logic                          core_ready_o,
    input  logic [NB_ARGS*DATA_WIDTH-1:0] core_operands_i,
    input  logic [OPCODE_WIDTH-1:0]       core_op_i,
    input  logic [FLAGS_IN_WIDTH-1:0]     core_flags_i,
    input  logic [REGADDR_WIDTH-1:0]      core_waddr_i,
    output logic                          apu_req_o,
    input  logic                          apu_gnt_i,
    output logic [ID_WIDTH-1:0]           apu_ID_o,
    output logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_o,
    output logic [OPCODE_WIDTH-1:0]       apu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]     apu_flags_o,
    output logic                          apu_rready_o,
    input  logic                          apu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         apu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]    apu_rflags_i,
    input  logic [ID_WIDTH-1:0]           apu_rID_i,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [DATA_WIDTH-1:0]         wb_data_o,
    output logic [FLAGS_OUT_WIDTH-1:0]    wb_flags_o,
    output logic [REGADDR_WIDTH-1:0]      wb_waddr_o,
    output logic                          busy_o,
    output logic                          err_o
);
    localparam int SW = $clog2(MAX_OUTSTANDING);
    localparam int CW = SW + 1;
    localparam int EW = DATA_WIDTH + FLAGS_OUT_WIDTH + REGADDR_WIDTH;

    logic [MAX_OUTSTANDING-1:0] slot_busy;
    logic [REGADDR_WIDTH-1:0]   slot_waddr [MAX_OUTSTANDING];
    logic [CW-1:0]              credits;
    logic [SW-1:0]              free_idx;
    logic                       have_free;
    logic                       accept;
    logic [SW-1:0]              rsp_slot;
    logic                       rsp_ok;
    logic                       rsp_bad;
    logic                       wb_pop;
    logic [EW-1:0]              rsp_dat;
    logic [EW-1:0]              head_dat;

    // Lowest free slot from the registered bitmap, so a slot freed this cycle waits a cycle.
    always_comb begin
        free_idx  = '0;
        have_free = 1'b0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                free_idx  = SW'(i);
                have_free = 1'b1;
            end
        end
    end

    assign core_ready_o = (!apu_req_o || apu_gnt_i) && have_free &&
                          (credits < CW'(MAX_OUTSTANDING));
    assign accept       = core_valid_i & core_ready_o;
    assign apu_rready_o = 1'b1;

    assign rsp_slot = apu_rID_i[SW-1:0];
    assign rsp_ok   = apu_rvalid_i && (apu_rID_i < ID_WIDTH'(MAX_OUTSTANDING)) &&
                      slot_busy[rsp_slot];
    assign rsp_bad  = apu_rvalid_i && !rsp_ok;
    assign rsp_dat  = {apu_rdata_i, apu_rflags_i, slot_waddr[rsp_slot]};

    assign wb_pop = wb_valid_o & wb_ready_i;
    assign busy_o = (credits != '0);
    assign {wb_data_o, wb_flags_o, wb_waddr_o} = head_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            apu_req_o      <= 1'b0;
            apu_ID_o       <= '0;
            apu_operands_o <= '0;
            apu_op_o       <= '0;
            apu_flags_o    <= '0;
        end else if (accept) begin
            apu_req_o      <= 1'b1;
            apu_ID_o       <= ID_WIDTH'(free_idx);
            apu_operands_o <= core_operands_i;
            apu_op_o       <= core_op_i;
            apu_flags_o    <= core_flags_i;
        end else if (apu_gnt_i) begin
            apu_req_o      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_busy <= '0;
            credits   <= '0;
            err_o     <= 1'b0;
        end else begin
            if (accept) slot_busy[free_idx] <= 1'b1;
            if (rsp_ok) slot_busy[rsp_slot] <= 1'b0;
            if (rsp_bad) err_o <= 1'b1;
            if (accept && !wb_pop) credits <= credits + 1'b1;
            else if (!accept && wb_pop) credits <= credits - 1'b1;
        end
    end

    // Only read back for a busy slot, which was written at allocation.
    always_ff @(posedge clk) begin
        if (accept) slot_waddr[free_idx] <= core_waddr_i;
    end

    apu_fifo #(
        .W     (EW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (rsp_ok),
        .wr_dat (rsp_dat),
        .rd_rdy (wb_ready_i),
        .rd_vld (wb_valid_o),
        .rd_dat (head_dat)
    );
endmodule

// File: tb/tb_apu_dispatcher.sv
// Directed bench for apu_dispatcher: vector table for single/out-of-order traffic, hand sequences for stalls, credits and reset.
module tb_apu_dispatcher;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_valid_i;
    logic        core_ready_o;
    logic [63:0] core_operands_i;
    logic [5:0]  core_op_i;
    logic [14:0] core_flags_i;
    logic [5:0]  core_waddr_i;
    logic        apu_req_o;
    logic        apu_gnt_i;
    logic [8:0]  apu_ID_o;
    logic [63:0] apu_operands_o;
    logic [5:0]  apu_op_o;
    logic [14:0] apu_flags_o;
    logic        apu_rready_o;
    logic        apu_rvalid_i;
    logic [31:0] apu_rdata_i;
    logic [4:0]  apu_rflags_i;
    logic [8:0]  apu_rID_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_flags_o;
    logic [5:0]  wb_waddr_o;
    logic        busy_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    apu_dispatcher dut (
        .clk(clk), .rst_n(rst_n),
        .core_valid_i(core_valid_i), .core_ready_o(core_ready_o),
        .core_operands_i(core_operands_i), .core_op_i(core_op_i),
        .core_flags_i(core_flags_i), .core_waddr_i(core_waddr_i),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_ID_o(apu_ID_o),
        .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
        .apu_rready_o(apu_rready_o), .apu_rvalid_i(apu_rvalid_i),
        .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i), .apu_rID_i(apu_rID_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .wb_flags_o(wb_flags_o), .wb_waddr_o(wb_waddr_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    typedef struct {
        logic        cv;
        logic [5:0]  wa;
        logic        gnt;
        logic        rv;
        logic [8:0]  rid;
        logic [31:0] rd;
        logic        wbr;
        logic        crdy;
        logic        req;
        logic [8:0]  id;
        logic        wbv;
        logic [5:0]  wwa;
        logic [31:0] wd;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t vecs [15];

    localparam logic [63:0] OPS_DEF = {32'h3F800000, 32'h40000000};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cv, input logic [5:0] wa, input logic g,
                         input logic rv, input logic [8:0] rid, input logic [31:0] rd,
                         input logic wbr);
        core_valid_i    = cv;
        core_waddr_i    = wa;
        core_op_i       = 6'h03;
        core_flags_i    = '0;
        core_operands_i = OPS_DEF;
        apu_gnt_i       = g;
        apu_rvalid_i    = rv;
        apu_rID_i       = rid;
        apu_rdata_i     = rd;
        apu_rflags_i    = rd[4:0];
        wb_ready_i      = wbr;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // cv wa gnt rv rid rd wbr | crdy req id wbv wwa wd busy err
        vecs[0]  = '{0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0,            0, 0};
        vecs[1]  = '{1, 5, 1, 0, 0, 0,            1, 1, 1, 0, 0, 0, 0,            1, 0};
        vecs[2]  = '{0, 0, 1, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0,            1, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0,            1, 0};
        vecs[4]  = '{0, 0, 0, 1, 0, 32'h40400000, 0, 1, 0, 0, 1, 5, 32'h40400000, 1, 0};
        vecs[5]  = '{0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 0, 0, 0,            0, 0};
        vecs[6]  = '{1, 1, 0, 0, 0, 0,            1, 1, 1, 0, 0, 0, 0,            1, 0};
        vecs[7]  = '{1, 2, 1, 0, 0, 0,            1, 1, 1, 1, 0, 0, 0,            1, 0};
        vecs[8]  = '{1, 3, 1, 0, 0, 0,            1, 1, 1, 2, 0, 0, 0,            1, 0};
        vecs[9]  = '{0, 0, 1, 0, 0, 0,            1, 1, 0, 2, 0, 0, 0,            1, 0};
        vecs[10] = '{0, 0, 0, 1, 2, 32'hC2,       0, 1, 0, 2, 1, 3, 32'hC2,       1, 0};
        vecs[11] = '{0, 0, 0, 1, 0, 32'hC0,       1, 1, 0, 2, 1, 1, 32'hC0,       1, 0};
        vecs[12] = '{0, 0, 0, 1, 1, 32'hC1,       1, 1, 0, 2, 1, 2, 32'hC1,       1, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0,            1, 1, 0, 2, 0, 0, 0,            0, 0};
        vecs[14] = '{0, 0, 0, 1, 7, 0,            1, 1, 0, 2, 0, 0, 0,            0, 1};

        drive(0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b0;
        #12;
        chk("rst_req", apu_req_o, 0);
        chk("rst_wbv", wb_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_id", apu_ID_o, 0);
        chk("rst_ops", apu_operands_o, 0);
        chk("rready", apu_rready_o, 1);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].cv, vecs[i].wa, vecs[i].gnt, vecs[i].rv, vecs[i].rid,
                  vecs[i].rd, vecs[i].wbr);
            #1;
            chk($sformatf("v%0d_crdy", i), core_ready_o, vecs[i].crdy);
            tick();
            chk($sformatf("v%0d_req", i), apu_req_o, vecs[i].req);
            chk($sformatf("v%0d_id", i), apu_ID_o, vecs[i].id);
            chk($sformatf("v%0d_wbv", i), wb_valid_o, vecs[i].wbv);
            chk($sformatf("v%0d_busy", i), busy_o, vecs[i].busy);
            chk($sformatf("v%0d_err", i), err_o, vecs[i].err);
            if (vecs[i].wbv) begin
                chk($sformatf("v%0d_wwa", i), wb_waddr_o, vecs[i].wwa);
                chk($sformatf("v%0d_wd", i), wb_data_o, vecs[i].wd);
                chk($sformatf("v%0d_wfl", i), wb_flags_o, vecs[i].wd[4:0]);
            end
            if (vecs[i].cv && vecs[i].crdy) begin
                chk($sformatf("v%0d_op", i), apu_op_o, 6'h03);
                chk($sformatf("v%0d_ops", i), apu_operands_o, OPS_DEF);
            end
        end

        // Credit limit: four ops fill the credits, responses fill the FIFO, one pop reopens one accept.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 6'(10 + i), 1, 0, 0, 0, 0);
            #1;
            chk("cred_crdy", core_ready_o, 1);
            tick();
            chk("cred_id", apu_ID_o, 9'(i));
            chk("cred_req", apu_req_o, 1);
        end
        drive(1, 14, 1, 0, 0, 0, 0);
        #1;
        chk("cred_full_crdy", core_ready_o, 0);
        tick();
        chk("cred_full_req", apu_req_o, 0);
        chk("cred_full_busy", busy_o, 1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 14, 1, 1, 9'(i), 32'h100 + i, 0);
            #1;
            chk("cred_rsp_crdy", core_ready_o, 0);
            tick();
            chk("cred_rsp_wbv", wb_valid_o, 1);
            chk("cred_rsp_wwa", wb_waddr_o, 10);
            chk("cred_rsp_wd", wb_data_o, 32'h100);
        end
        drive(1, 14, 1, 0, 0, 0, 1);
        #1;
        chk("cred_pop_crdy", core_ready_o, 0);
        tick();
        chk("cred_pop_wwa", wb_waddr_o, 11);
        chk("cred_pop_wd", wb_data_o, 32'h101);
        drive(1, 14, 1, 0, 0, 0, 0);
        #1;
        chk("cred_reopen_crdy", core_ready_o, 1);
        tick();
        chk("cred_reopen_req", apu_req_o, 1);
        chk("cred_reopen_id", apu_ID_o, 0);
        drive(1, 15, 1, 0, 0, 0, 0);
        #1;
        chk("cred_closed_crdy", core_ready_o, 0);
        tick();
        chk("cred_closed_req", apu_req_o, 0);

        // Grant stall: request contents hold while the core presents new values.
        do_reset();
        drive(1, 7, 0, 0, 0, 0, 1);
        core_op_i       = 6'h2A;
        core_flags_i    = 15'h1234;
        core_operands_i = {32'hAAAA0001, 32'hBBBB0002};
        #1;
        chk("stall_crdy0", core_ready_o, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 8, 0, 0, 0, 0, 1);
            core_op_i       = 6'h15;
            core_flags_i    = 15'h0F0F;
            core_operands_i = {32'h11111111, 32'h22222222};
            #1;
            chk("stall_crdy", core_ready_o, 0);
            tick();
            chk("stall_req", apu_req_o, 1);
            chk("stall_id", apu_ID_o, 0);
            chk("stall_op", apu_op_o, 6'h2A);
            chk("stall_flags", apu_flags_o, 15'h1234);
            chk("stall_ops", apu_operands_o, {32'hAAAA0001, 32'hBBBB0002});
        end
        apu_gnt_i = 1'b1;
        #1;
        chk("b2b_crdy", core_ready_o, 1);
        tick();
        chk("b2b_req", apu_req_o, 1);
        chk("b2b_id", apu_ID_o, 1);
        chk("b2b_op", apu_op_o, 6'h15);
        chk("b2b_ops", apu_operands_o, {32'h11111111, 32'h22222222});
        drive(0, 0, 1, 0, 0, 0, 1);
        tick();
        chk("b2b_done_req", apu_req_o, 0);

        // Out-of-range ID whose low bits hit a busy slot.
        drive(0, 0, 0, 1, 9'd4, 32'hDEAD, 1);
        tick();
        chk("badid_err", err_o, 1);
        chk("badid_wbv", wb_valid_o, 0);
        chk("badid_busy", busy_o, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("badid_sticky", err_o, 1);

        // Reset with two ops in flight clears everything without waiting for a clock.
        rst_n = 1'b0;
        #1;
        chk("mrst_req", apu_req_o, 0);
        chk("mrst_id", apu_ID_o, 0);
        chk("mrst_ops", apu_operands_o, 0);
        chk("mrst_op", apu_op_o, 0);
        chk("mrst_flags", apu_flags_o, 0);
        chk("mrst_wbv", wb_valid_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_err", err_o, 0);
        chk("mrst_crdy", core_ready_o, 1);
        tick();
        rst_n = 1'b1;
        drive(1, 9, 1, 0, 0, 0, 0);
        tick();
        chk("post_rst_id", apu_ID_o, 0);
        chk("post_rst_req", apu_req_o, 1);
        drive(0, 0, 1, 1, 9'd1, 32'hBEEF, 0);
        tick();
        chk("stale_err", err_o, 1);
        chk("stale_wbv", wb_valid_o, 0);
        chk("stale_busy", busy_o, 1);
        drive(0, 0, 0, 1, 9'd0, 32'h5A5A, 0);
        tick();
        chk("post_rst_wbv", wb_valid_o, 1);
        chk("post_rst_wwa", wb_waddr_o, 9);
        chk("post_rst_wd", wb_data_o, 32'h5A5A);
        chk("post_rst_err", err_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apu_dispatcher.md
Name: apu_dispatcher

Overview:
Initiator (core-side master) for the APU request/response protocol served by the FPU wrapper.
- Accepts FP operations from the core pipeline over a valid/ready interface.
- Drives the APU req/gnt request channel and tags each operation with a slot ID.
- Collects possibly out-of-order responses by ID and returns them in arrival order, with the destination register address, to the core write-back port.
- Credit-based flow control ensures responses are never dropped, so apu_rready_o is tied high.

Parameters:
ID_WIDTH, 9, APU tag width; slot index is zero-extended into it.
NB_ARGS, 2, number of operands.
OPCODE_WIDTH, 6, APU opcode width.
DATA_WIDTH, 32, operand and result width.
FLAGS_IN_WIDTH, 15, request flags width.
FLAGS_OUT_WIDTH, 5, response status width.
REGADDR_WIDTH, 6, destination register address width.
MAX_OUTSTANDING, 4, slots and response FIFO depth; power of 2, 2..16, and ≤ 2^ID_WIDTH.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
core_valid_i  in  1  core op valid
core_ready_o  out  1  dispatcher accepts op
core_operands_i  in  NB_ARGS*DATA_WIDTH  operands
core_op_i  in  OPCODE_WIDTH  opcode
core_flags_i  in  FLAGS_IN_WIDTH  flags
core_waddr_i  in  REGADDR_WIDTH  destination register
apu_req_o  out  1  APU request
apu_gnt_i  in  1  APU grant
apu_ID_o  out  ID_WIDTH  tag
apu_operands_o  out  NB_ARGS*DATA_WIDTH  operands
apu_op_o  out  OPCODE_WIDTH  opcode
apu_flags_o  out  FLAGS_IN_WIDTH  flags
apu_rready_o  out  1  constant 1
apu_rvalid_i  in  1  response valid
apu_rdata_i  in  DATA_WIDTH  result
apu_rflags_i  in  FLAGS_OUT_WIDTH  status
apu_rID_i  in  ID_WIDTH  response tag
wb_valid_o  out  1  write-back valid
wb_ready_i  in  1  write-back ready
wb_data_o  out  DATA_WIDTH  result
wb_flags_o  out  FLAGS_OUT_WIDTH  status
wb_waddr_o  out  REGADDR_WIDTH  destination register
busy_o  out  1  any op in flight or buffered
err_o  out  1  sticky unknown-ID error

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: apu_req_o=0, wb_valid_o=0, busy_o=0, err_o=0, all data/ID outputs=0, credit count=0, slot bitmap all free, FIFO empty.

Issue register (one entry):
- core_ready_o = (issue reg empty OR apu_gnt_i&apu_req_o) AND a free slot exists AND credits < MAX_OUTSTANDING.
- Accept on core_valid_i&core_ready_o:
  - capture operands, op and flags;
  - allocate the lowest free slot, mark it busy, store core_waddr_i in the slot table;
  - increment credits.
- apu_req_o rises the cycle after accept.
- While apu_req_o=1 and apu_gnt_i=0, all apu_* request outputs hold stable.
- Back-to-back: a grant and a new accept in the same cycle keep apu_req_o=1 with the new contents.

Response:
- On apu_rvalid_i, slot = apu_rID_i[log2(MAX_OUTSTANDING)-1:0].
- If apu_rID_i ≥ MAX_OUTSTANDING or the slot is not busy: set err_o (sticky until reset), discard, credits unchanged.
- Else, same cycle:
  - push {rdata, rflags, slot waddr} into the FIFO;
  - free the slot.
- A slot freed this cycle is not allocatable until the next cycle.

Write-back:
- wb_valid_o = FIFO not empty; head visible the cycle after push.
- Pop on wb_valid_o&wb_ready_i, which decrements credits.
- Accept and pop in the same cycle: credits unchanged.
- Credits count accepted-but-unpopped ops, so the FIFO can never overflow.
- Push and pop in the same cycle are both honoured, including when the FIFO is full with a pop.

busy_o = credits != 0.
- Asserting rst_n low mid-operation clears all state immediately; in-flight responses after reset are reported through err_o.

Test Plan:
1. Reset, single op: core op=0x03, waddr=5, operands {0x3F800000,0x40000000}; APU grants at once and responds 3 cycles later with ID 0, rdata 0x40400000 → apu_req_o 1 cycle after accept, apu_ID_o=0, wb_data_o=0x40400000, wb_waddr_o=5, busy_o returns to 0.
2. Grant stall: apu_gnt_i low for 4 cycles → apu_req_o, ID, operands, op and flags stable throughout; core_ready_o=0 until the grant.
3. Out-of-order: issue 3 ops to waddr 1,2,3 (IDs 0,1,2); respond IDs 2,0,1 → write-back order waddr 3,1,2 with matching data.
4. Credit limit: wb_ready_i=0, issue 4 ops, all responses return → core_ready_o=0 on the 5th; one pop reopens exactly one accept.
5. Bad ID: rvalid with rID=7, or an ID whose slot is free → err_o=1, no FIFO push, credits unchanged; err_o persists until reset.
6. Reset mid-flight: 2 ops outstanding, drop rst_n → all outputs at reset values the same cycle; the next accept uses ID 0.
